// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract that time-shares one external CLA slice.
// Words are processed LSW first, and the carry between words passes through a register.
module cla_multiword_seq #(
  parameter int ADDER_SIZE = 16,
  parameter int NUM_WORDS  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDER_SIZE*NUM_WORDS-1:0]   in_a,
  input  logic [ADDER_SIZE*NUM_WORDS-1:0]   in_b,
  input  logic                              in_cin,
  input  logic                              in_sub,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ADDER_SIZE*NUM_WORDS-1:0]   out_sum,
  output logic                              out_cout,
  output logic                              out_ovf,
  output logic                              busy,
  output logic [ADDER_SIZE-1:0]             add_a,
  output logic [ADDER_SIZE-1:0]             add_b,
  output logic                              add_cin,
  input  logic [ADDER_SIZE-1:0]             add_sum,
  input  logic                              add_cout
);

  localparam int W     = ADDER_SIZE * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                               state_q, state_d;
  logic [NUM_WORDS-1:0][ADDER_SIZE-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 carry_q, carry_d;
  logic                                 out_valid_q, out_valid_d;
  logic [W-1:0]                         out_sum_q, out_sum_d;
  logic                                 out_cout_q, out_cout_d;
  logic                                 out_ovf_q, out_ovf_d;
  logic                                 busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_cin ^ in_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a        = a_q[cnt_q];
        add_b        = b_q[cnt_q];
        add_cin      = carry_q;
        sum_d[cnt_q] = add_sum;
        carry_d      = add_cout;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        // Outputs register one cycle after entering DONE; the handshake only counts once they are visible.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_sum_d   = sum_q;
          out_cout_d  = carry_q;
          out_ovf_d   = (a_q[NUM_WORDS-1][ADDER_SIZE-1] == b_q[NUM_WORDS-1][ADDER_SIZE-1]) &&
                        (sum_q[NUM_WORDS-1][ADDER_SIZE-1] != a_q[NUM_WORDS-1][ADDER_SIZE-1]);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Bench for cla_multiword_seq: a behavioural CLA slice, directed corner cases,
// and random ops checked against 65-bit arithmetic.
module tb_cla_multiword_seq;

  localparam int AS = 16;
  localparam int NW = 4;
  localparam int W  = AS * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic          out_valid, out_ready, out_cout, out_ovf, busy;
  logic [AS-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic [AS:0]   add_res;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {{AS{1'b0}}, add_cin};
  assign add_sum  = add_res[AS-1:0];
  assign add_cout = add_res[AS];

  cla_multiword_seq #(.ADDER_SIZE(AS), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: true W-bit add or subtract, flags from operand/result signs.
  task automatic model(input logic [W-1:0] a, b, input logic cin, sub,
                       output logic [W-1:0] s, output logic c, output logic o);
    logic [W:0] r;
    if (sub) begin
      r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      c = ~r[W];
      o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      c = r[W];
      o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    s = r[W-1:0];
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, b, input logic cin, sub,
                        input int hold, input bit spam, input logic [W-1:0] sa, sb);
    logic [W-1:0] es;
    logic ec, eo;
    int n;
    model(a, b, cin, sub, es, ec, eo);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_in_ready"}, (W+1)'(in_ready), (W+1)'(1));
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy_ready"}, (W+1)'({busy, in_ready}), (W+1)'(2'b10));
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, (W+1)'(n), (W+1)'(NW + 1));
    chk({tag, "_sum"}, {1'b0, out_sum}, {1'b0, es});
    chk({tag, "_cout_ovf"}, (W+1)'({out_cout, out_ovf}), (W+1)'({ec, eo}));
    for (int h = 0; h < hold; h++) begin
      if (spam) begin
        in_valid = 1'b1; in_a = sa; in_b = sb; in_cin = 1'b0; in_sub = 1'b0;
      end
      tick();
      chk({tag, "_hold"}, {out_valid, in_ready, out_sum[W-2:0]}, {1'b1, 1'b0, es[W-2:0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, (W+1)'({out_valid, busy, in_ready}), (W+1)'(3'b001));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_flags", (W+1)'({out_valid, busy, in_ready, out_cout, out_ovf}), (W+1)'(5'b00100));
    chk("reset_sum", {1'b0, out_sum}, '0);
    chk("reset_adder_if", (W+1)'({add_a, add_b, add_cin}), '0);

    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    chk("add_wrap_exact", {1'b0, out_sum}, '0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    run_op("sub_neg", 64'h5, 64'h7, 1'b0, 1'b1, 0, 1'b0, '0, '0);
    run_op("sub_borrow", 64'h7, 64'h5, 1'b1, 1'b1, 0, 1'b0, '0, '0);

    // Back-pressure with competing operands, then the queued op runs.
    run_op("stall", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 10, 1'b1,
           64'hAAAA_0000_0000_0001, 64'h5555_0000_0000_0002);
    run_op("after_stall", 64'hAAAA_0000_0000_0001, 64'h5555_0000_0000_0002, 1'b0, 1'b0, 0, 1'b0,
           '0, '0);

    // Reset while the third word is in flight.
    in_valid = 1'b1; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_cin = 1'b0; in_sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run_flags", (W+1)'({out_valid, busy, in_ready}), (W+1)'(3'b001));
    chk("rst_run_adder_if", (W+1)'({add_a, add_b, add_cin}), '0);
    run_op("post_rst", 64'h3, 64'h4, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    chk("post_rst_exact", {1'b0, out_sum}, (W+1)'(7));

    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 17 == 0) ra = '1;
      if (i % 23 == 0) rb = {1'b0, {(W-1){1'b1}}};
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
